// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding,
// owner constants and default widths.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DEF  = 5;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int MEM_LATENCY_DEF = 2;
  localparam int MAX_WAIT_DEF    = 3;
  // Wide enough for the 1..15 range of both MEM_LATENCY and MAX_WAIT.
  localparam int CNT_WIDTH       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between CPU and debug requests, with a saturating count of
// CPU grants taken while debug was waiting.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic grant_strobe,
  input  logic idle,
  output logic grant_valid,
  output logic grant_dbg
);

  localparam logic [CNT_WIDTH-1:0] WAIT_MAX = CNT_WIDTH'(MAX_WAIT);

  logic [CNT_WIDTH-1:0] wait_cnt_reg;
  logic [CNT_WIDTH-1:0] wait_cnt_next;

  // CPU has priority unless debug has already been passed over MAX_WAIT times.
  always_comb begin
    grant_valid = cpu_req | dbg_req;
    grant_dbg   = dbg_req & (~cpu_req | (wait_cnt_reg == WAIT_MAX));
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (grant_strobe) begin
      if (grant_dbg || !dbg_req) begin
        wait_cnt_next = '0;
      end else if (wait_cnt_reg != WAIT_MAX) begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
      end
    end else if (idle && !dbg_req) begin
      wait_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and debug accesses onto a single-port memory with a fixed
// multi-cycle access time; acks pulse one cycle after the access ends.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int MAX_WAIT    = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_wr,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  localparam logic [CNT_WIDTH-1:0] LAT_INIT = CNT_WIDTH'(MEM_LATENCY - 1);

  arb_state_t           state_reg, state_next;
  logic [CNT_WIDTH-1:0] lat_cnt_reg, lat_cnt_next;
  logic                 mem_en_reg, mem_en_next;
  logic                 mem_we_reg, mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic                 owner_reg, owner_next;
  logic                 cpu_ack_reg, cpu_ack_next;
  logic                 dbg_ack_reg, dbg_ack_next;
  logic [DATA_WIDTH-1:0] cpu_rdata_reg, cpu_rdata_next;
  logic [DATA_WIDTH-1:0] dbg_rdata_reg, dbg_rdata_next;
  logic                 busy_reg, busy_next;

  logic idle;
  logic grant_valid;
  logic grant_dbg;
  logic grant_strobe;

  assign idle         = (state_reg == IDLE);
  assign grant_strobe = idle & grant_valid;

  mem_arb_prio #(
    .MAX_WAIT(MAX_WAIT)
  ) u_prio (
    .clk         (clk),
    .n_rst       (n_rst),
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .grant_strobe(grant_strobe),
    .idle        (idle),
    .grant_valid (grant_valid),
    .grant_dbg   (grant_dbg)
  );

  always_comb begin
    state_next     = state_reg;
    lat_cnt_next   = lat_cnt_reg;
    mem_en_next    = mem_en_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    owner_next     = owner_reg;
    cpu_ack_next   = 1'b0;
    dbg_ack_next   = 1'b0;
    cpu_rdata_next = cpu_rdata_reg;
    dbg_rdata_next = dbg_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next     = grant_dbg ? OWN_DBG : OWN_CPU;
          mem_en_next    = 1'b1;
          mem_we_next    = grant_dbg ? dbg_wr : cpu_wr;
          mem_addr_next  = grant_dbg ? dbg_addr : cpu_addr;
          mem_wdata_next = grant_dbg ? dbg_wdata : cpu_wdata;
          lat_cnt_next   = LAT_INIT;
          state_next     = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt_reg == '0) begin
          // Last cycle of the access: mem_rdata is valid now.
          if (!mem_we_reg) begin
            if (owner_reg == OWN_DBG) begin
              dbg_rdata_next = mem_rdata;
            end else begin
              cpu_rdata_next = mem_rdata;
            end
          end
          cpu_ack_next = (owner_reg == OWN_CPU);
          dbg_ack_next = (owner_reg == OWN_DBG);
          mem_en_next  = 1'b0;
          mem_we_next  = 1'b0;
          state_next   = DONE;
        end else begin
          lat_cnt_next = lat_cnt_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      lat_cnt_reg   <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      owner_reg     <= OWN_CPU;
      cpu_ack_reg   <= 1'b0;
      dbg_ack_reg   <= 1'b0;
      cpu_rdata_reg <= '0;
      dbg_rdata_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lat_cnt_reg   <= lat_cnt_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      owner_reg     <= owner_next;
      cpu_ack_reg   <= cpu_ack_next;
      dbg_ack_reg   <= dbg_ack_next;
      cpu_rdata_reg <= cpu_rdata_next;
      dbg_rdata_reg <= dbg_rdata_next;
      busy_reg      <= busy_next;
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign owner     = owner_reg;
  assign cpu_ack   = cpu_ack_reg;
  assign dbg_ack   = dbg_ack_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign dbg_rdata = dbg_rdata_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (latency 2 / max-wait 3, and latency 1 / max-wait 1) driven by
// random requesters and checked cycle by cycle against a transaction timeline.
module tb_mem_port_arbiter;

  localparam int AW     = 5;
  localparam int DW     = 8;
  localparam int CYCLES = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst     [2];
  logic          cpu_req   [2];
  logic          cpu_wr    [2];
  logic [AW-1:0] cpu_addr  [2];
  logic [DW-1:0] cpu_wdata [2];
  logic          cpu_ack   [2];
  logic [DW-1:0] cpu_rdata [2];
  logic          dbg_req   [2];
  logic          dbg_wr    [2];
  logic [AW-1:0] dbg_addr  [2];
  logic [DW-1:0] dbg_wdata [2];
  logic          dbg_ack   [2];
  logic [DW-1:0] dbg_rdata [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy      [2];
  logic          owner     [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : 1;
    localparam int MW  = (gi == 0) ? 3 : 1;

    logic [DW-1:0] mem [32];
    int en_cycles = 0;

    mem_port_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_LATENCY(LAT),
      .MAX_WAIT   (MW)
    ) u_dut (
      .clk      (clk),
      .n_rst    (n_rst[gi]),
      .cpu_req  (cpu_req[gi]),
      .cpu_wr   (cpu_wr[gi]),
      .cpu_addr (cpu_addr[gi]),
      .cpu_wdata(cpu_wdata[gi]),
      .cpu_ack  (cpu_ack[gi]),
      .cpu_rdata(cpu_rdata[gi]),
      .dbg_req  (dbg_req[gi]),
      .dbg_wr   (dbg_wr[gi]),
      .dbg_addr (dbg_addr[gi]),
      .dbg_wdata(dbg_wdata[gi]),
      .dbg_ack  (dbg_ack[gi]),
      .dbg_rdata(dbg_rdata[gi]),
      .mem_en   (mem_en[gi]),
      .mem_we   (mem_we[gi]),
      .mem_addr (mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]),
      .mem_rdata(mem_rdata[gi]),
      .busy     (busy[gi]),
      .owner    (owner[gi])
    );

    initial begin
      for (int a = 0; a < 32; a++) mem[a] = DW'(a * 37 + gi * 11 + 5);
    end

    // Memory only presents true data in the last enabled cycle of an access.
    always @(posedge clk) begin
      if (mem_en[gi] && mem_we[gi]) mem[mem_addr[gi]] = mem_wdata[gi];
      en_cycles <= mem_en[gi] ? en_cycles + 1 : 0;
    end

    assign mem_rdata[gi] = (mem_en[gi] && en_cycles == LAT - 1) ?
                           mem[mem_addr[gi]] : ~mem[mem_addr[gi]];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Reference model: one in-flight transaction per arbiter, on a cycle timeline.
  int            nfree     [2];
  int            g_edge    [2];
  int            waitc     [2];
  bit            g_dbg     [2];
  bit            g_wr      [2];
  logic [AW-1:0] g_addr    [2];
  logic [DW-1:0] g_wdata   [2];
  logic [DW-1:0] g_rdata   [2];
  bit            exp_owner [2];
  logic [DW-1:0] exp_cpu_rd[2];
  logic [DW-1:0] exp_dbg_rd[2];
  logic [DW-1:0] ref_mem   [2][32];
  bit            cpu_pend  [2];
  bit            dbg_pend  [2];
  bit            rst_req   [2];

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int mw(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic check_zero(input int i, input string when);
    check($sformatf("u%0d %s mem_en", i, when), 32'(mem_en[i]), 0);
    check($sformatf("u%0d %s mem_we", i, when), 32'(mem_we[i]), 0);
    check($sformatf("u%0d %s mem_addr", i, when), 32'(mem_addr[i]), 0);
    check($sformatf("u%0d %s mem_wdata", i, when), 32'(mem_wdata[i]), 0);
    check($sformatf("u%0d %s busy", i, when), 32'(busy[i]), 0);
    check($sformatf("u%0d %s owner", i, when), 32'(owner[i]), 0);
    check($sformatf("u%0d %s cpu_ack", i, when), 32'(cpu_ack[i]), 0);
    check($sformatf("u%0d %s dbg_ack", i, when), 32'(dbg_ack[i]), 0);
    check($sformatf("u%0d %s cpu_rdata", i, when), 32'(cpu_rdata[i]), 0);
    check($sformatf("u%0d %s dbg_rdata", i, when), 32'(dbg_rdata[i]), 0);
  endtask

  task automatic model_reset(input int i);
    nfree[i]      = edge_n + 1;
    g_edge[i]     = -100;
    waitc[i]      = 0;
    g_dbg[i]      = 0;
    g_wr[i]       = 0;
    exp_owner[i]  = 0;
    exp_cpu_rd[i] = '0;
    exp_dbg_rd[i] = '0;
    cpu_pend[i]   = 0;
    dbg_pend[i]   = 0;
    cpu_req[i]    = 0;
    dbg_req[i]    = 0;
  endtask

  task automatic step(input int i);
    int L;
    bit dw, en_e, busy_e, ack_c, ack_d, contend;
    L = lat(i);
    contend = (edge_n < 40);

    // Arbitration decision for the edge just taken, from the inputs it sampled.
    if (edge_n >= nfree[i]) begin
      if (cpu_req[i] || dbg_req[i]) begin
        dw           = dbg_req[i] && (!cpu_req[i] || waitc[i] == mw(i));
        g_edge[i]    = edge_n;
        nfree[i]     = edge_n + L + 2;
        g_dbg[i]     = dw;
        exp_owner[i] = dw;
        g_wr[i]      = dw ? dbg_wr[i] : cpu_wr[i];
        g_addr[i]    = dw ? dbg_addr[i] : cpu_addr[i];
        g_wdata[i]   = dw ? dbg_wdata[i] : cpu_wdata[i];
        if (dw || !dbg_req[i]) waitc[i] = 0;
        else if (waitc[i] < mw(i)) waitc[i]++;
        if (g_wr[i]) ref_mem[i][g_addr[i]] = g_wdata[i];
        else         g_rdata[i] = ref_mem[i][g_addr[i]];
      end else if (!dbg_req[i]) begin
        waitc[i] = 0;
      end
    end

    en_e   = (edge_n >= g_edge[i]) && (edge_n <= g_edge[i] + L - 1);
    busy_e = (edge_n >= g_edge[i]) && (edge_n <= g_edge[i] + L);
    ack_c  = (edge_n == g_edge[i] + L) && !g_dbg[i];
    ack_d  = (edge_n == g_edge[i] + L) && g_dbg[i];
    if (ack_c && !g_wr[i]) exp_cpu_rd[i] = g_rdata[i];
    if (ack_d && !g_wr[i]) exp_dbg_rd[i] = g_rdata[i];

    check($sformatf("u%0d cpu_ack", i), 32'(cpu_ack[i]), 32'(ack_c));
    check($sformatf("u%0d dbg_ack", i), 32'(dbg_ack[i]), 32'(ack_d));
    check($sformatf("u%0d mem_en", i), 32'(mem_en[i]), 32'(en_e));
    check($sformatf("u%0d mem_we", i), 32'(mem_we[i]), 32'(en_e && g_wr[i]));
    check($sformatf("u%0d busy", i), 32'(busy[i]), 32'(busy_e));
    check($sformatf("u%0d owner", i), 32'(owner[i]), 32'(exp_owner[i]));
    check($sformatf("u%0d cpu_rdata", i), 32'(cpu_rdata[i]), 32'(exp_cpu_rd[i]));
    check($sformatf("u%0d dbg_rdata", i), 32'(dbg_rdata[i]), 32'(exp_dbg_rd[i]));
    if (en_e) check($sformatf("u%0d mem_addr", i), 32'(mem_addr[i]), 32'(g_addr[i]));
    if (en_e && g_wr[i])
      check($sformatf("u%0d mem_wdata", i), 32'(mem_wdata[i]), 32'(g_wdata[i]));

    if (ack_c || ack_d)
      $display("[TB] u%0d cycle %0d %s %s addr=%02h data=%02h", i, edge_n,
               g_dbg[i] ? "DBG" : "CPU", g_wr[i] ? "WR" : "RD", g_addr[i],
               g_wr[i] ? g_wdata[i] : g_rdata[i]);

    // Requesters: drop or renew on ack; fields wander every cycle.
    if (ack_c) cpu_pend[i] = 0;
    if (ack_d) dbg_pend[i] = 0;
    if (!cpu_pend[i] && (contend || $urandom_range(2) == 0)) cpu_pend[i] = 1;
    if (!dbg_pend[i] && (contend || $urandom_range(3) == 0)) dbg_pend[i] = 1;
    cpu_req[i] = (!contend && en_e && !g_dbg[i]) ? ($urandom_range(1) == 1) : cpu_pend[i];
    dbg_req[i] = (!contend && en_e && g_dbg[i])  ? ($urandom_range(1) == 1) : dbg_pend[i];
    cpu_wr[i]    = ($urandom_range(1) == 1);
    cpu_addr[i]  = AW'($urandom);
    cpu_wdata[i] = DW'($urandom);
    dbg_wr[i]    = ($urandom_range(1) == 1);
    dbg_addr[i]  = AW'($urandom);
    dbg_wdata[i] = DW'($urandom);

    rst_req[i] = (edge_n > 60) && en_e && !g_wr[i] && ($urandom_range(15) == 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_rst[i] = 1'b1;
      for (int a = 0; a < 32; a++) ref_mem[i][a] = DW'(a * 37 + i * 11 + 5);
      model_reset(i);
      nfree[i] = 0;
      cpu_wr[i] = 0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      dbg_wr[i] = 0; dbg_addr[i] = '0; dbg_wdata[i] = '0;
      rst_req[i] = 0;
    end
    #1;
    for (int i = 0; i < 2; i++) n_rst[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_zero(i, "reset");
    #3;
    for (int i = 0; i < 2; i++) n_rst[i] = 1'b1;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      edge_n++;
      #1;
      for (int i = 0; i < 2; i++) step(i);
      #1;
      for (int i = 0; i < 2; i++) if (rst_req[i]) n_rst[i] = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        if (rst_req[i]) begin
          check_zero(i, "midreset");
          model_reset(i);
        end
      end
      #1;
      for (int i = 0; i < 2; i++) n_rst[i] = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
